// File: rtl/svarog_pkg.sv
// Shared types and constants for the Svarog memory arbiter.
// Arbiter states, grant encoding and the default error read-data pattern.
package svarog_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } arb_grant_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic arb_grant_t other_grant(input arb_grant_t g);
        return (g == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    endfunction

endpackage

// File: rtl/svarog_rr_arb2.sv
// Combinational two-way round-robin pick between instruction (bit 0) and data (bit 1).
// On a tie the requester that was not granted last wins.
module svarog_rr_arb2
    import svarog_pkg::*;
(
    input  logic [1:0] req,
    input  arb_grant_t last,
    output logic       valid,
    output arb_grant_t gnt
);

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        valid = |req;
        gnt   = GNT_INSTR;
        unique case (req)
            2'b10:   gnt = GNT_DATA;
            2'b11:   gnt = other_grant(last);
            default: gnt = GNT_INSTR;
        endcase
    end

endmodule

// File: rtl/svarog_mem_arbiter.sv
// Shares one single-port memory between the instruction and data interfaces of the core.
// Round-robin, one transaction in flight, with a watchdog that completes hung accesses with an error.
module svarog_mem_arbiter
    import svarog_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  instr_req_i,
    input  logic [DATA_WIDTH-1:0] instr_addr_i,
    output logic                  instr_ready_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_write_i,
    input  logic [DATA_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_ready_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] err_addr_o
);

    arb_state_t            state;
    arb_state_t            state_next;
    arb_grant_t            last_grant;
    arb_grant_t            arb_gnt;
    logic                  arb_valid;
    logic                  busy;
    logic                  timeout_hit;
    logic                  xfer_done;
    logic [DATA_WIDTH-1:0] done_rdata;
    logic [DATA_WIDTH-1:0] instr_rdata_q;
    logic [DATA_WIDTH-1:0] data_rdata_q;
    logic [DATA_WIDTH-1:0] err_addr_q;
    logic                  err_q;

    svarog_rr_arb2 u_rr_arb2 (
        .req   ({data_req_i, instr_req_i}),
        .last  (last_grant),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    assign busy      = (state != ARB_IDLE);
    assign xfer_done = busy & (mem_ready_i | timeout_hit);

    // The watchdog fires in the last allowed BUSY cycle unless the memory answers in that same cycle.
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            logic [CNT_W-1:0] timeout_cnt;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    timeout_cnt <= '0;
                end else if (busy && !xfer_done) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end else begin
                    timeout_cnt <= '0;
                end
            end

            assign timeout_hit = busy && !mem_ready_i &&
                                 (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next    = state;
        mem_req_o     = busy;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        done_rdata    = timeout_hit ? ERR_RDATA : mem_rdata_i;
        instr_ready_o = 1'b0;
        data_ready_o  = 1'b0;

        unique case (state)
            ARB_IDLE: begin
                if (arb_valid) begin
                    state_next = (arb_gnt == GNT_DATA) ? ARB_BUSY_D : ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                mem_addr_o    = instr_addr_i;
                instr_ready_o = xfer_done;
                // The finishing requester is ignored this cycle; the other one gets a back-to-back grant.
                if (xfer_done) begin
                    state_next = data_req_i ? ARB_BUSY_D : ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                mem_addr_o   = data_addr_i;
                mem_wdata_o  = data_wdata_i;
                mem_write_o  = data_write_i;
                data_ready_o = xfer_done;
                if (xfer_done) begin
                    state_next = instr_req_i ? ARB_BUSY_I : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        instr_rdata_o = instr_ready_o ? done_rdata : instr_rdata_q;
        data_rdata_o  = data_ready_o  ? done_rdata : data_rdata_q;
    end

    // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ARB_IDLE;
            last_grant    <= GNT_INSTR;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state <= state_next;
            if (xfer_done) begin
                last_grant <= (state == ARB_BUSY_D) ? GNT_DATA : GNT_INSTR;
            end
            if (instr_ready_o) begin
                instr_rdata_q <= done_rdata;
            end
            if (data_ready_o) begin
                data_rdata_q <= done_rdata;
            end
            if (timeout_hit && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= mem_addr_o;
            end
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_svarog_mem_arbiter.sv
// Self-checking bench for svarog_mem_arbiter: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_svarog_mem_arbiter;

    localparam int          DW  = 32;
    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          instr_req_i;
    logic [DW-1:0] instr_addr_i;
    logic          instr_ready_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic          data_write_i;
    logic [DW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_ready_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic          mem_write_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic [DW-1:0] mem_rdata_i;
    logic          err_o;
    logic [DW-1:0] err_addr_o;

    svarog_mem_arbiter #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_ready_o (instr_ready_o),
        .instr_rdata_o (instr_rdata_o),
        .data_req_i    (data_req_i),
        .data_write_i  (data_write_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_ready_o  (data_ready_o),
        .data_rdata_o  (data_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i),
        .err_o         (err_o),
        .err_addr_o    (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: who owns the memory (-1 none, 0 instr, 1 data), how long it has waited.
    int          m_owner;
    int          m_wait;
    int          m_last;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;

    logic        e_done;
    logic        e_to;
    logic        e_iready;
    logic        e_dready;
    logic [31:0] e_addr;
    logic [31:0] e_rdata;
    logic        s_ireq;
    logic        s_dreq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_wait     = 0;
        m_last     = 0;
        m_err      = 1'b0;
        m_err_addr = '0;
        m_irdata   = '0;
        m_drdata   = '0;
    endtask

    task automatic clear_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_write_i = 1'b0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_ready_i  = 1'b0;
        mem_rdata_i  = '0;
    endtask

    // Called just after the falling edge once inputs are driven: predict and compare this cycle.
    task automatic settle();
        #1;
        s_ireq   = instr_req_i;
        s_dreq   = data_req_i;
        e_addr   = (m_owner == 0) ? instr_addr_i : (m_owner == 1) ? data_addr_i : 32'h0;
        e_to     = (m_owner >= 0) && !mem_ready_i && (m_wait + 1 == TO);
        e_done   = (m_owner >= 0) && (mem_ready_i || e_to);
        e_iready = e_done && (m_owner == 0);
        e_dready = e_done && (m_owner == 1);
        e_rdata  = e_to ? ERR : mem_rdata_i;

        check_bit("mem_req", mem_req_o, m_owner >= 0);
        check_bit("mem_write", mem_write_o, (m_owner == 1) && data_write_i);
        check("mem_addr", mem_addr_o, e_addr);
        check("mem_wdata", mem_wdata_o, (m_owner == 1) ? data_wdata_i : 32'h0);
        check_bit("instr_ready", instr_ready_o, e_iready);
        check("instr_rdata", instr_rdata_o, e_iready ? e_rdata : m_irdata);
        check_bit("data_ready", data_ready_o, e_dready);
        check("data_rdata", data_rdata_o, e_dready ? e_rdata : m_drdata);
        check_bit("err", err_o, m_err);
        check("err_addr", err_addr_o, m_err_addr);
    endtask

    // Step the model across the rising edge and return at the next falling edge.
    task automatic advance();
        int other;
        @(posedge clk_i);
        if (e_done) begin
            if (m_owner == 0) m_irdata = e_rdata;
            else              m_drdata = e_rdata;
            if (e_to && !m_err) begin
                m_err      = 1'b1;
                m_err_addr = e_addr;
            end
            m_last = m_owner;
            other  = 1 - m_owner;
            if ((other == 0 && s_ireq) || (other == 1 && s_dreq)) begin
                m_owner = other;
                m_wait  = 0;
            end else begin
                m_owner = -1;
            end
        end else if (m_owner >= 0) begin
            m_wait++;
        end else begin
            if (s_ireq && s_dreq) m_owner = 1 - m_last;
            else if (s_ireq)      m_owner = 0;
            else if (s_dreq)      m_owner = 1;
            m_wait = 0;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        bit i_pend;
        bit d_pend;

        reset_i = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        check_bit("rst_mem_req", mem_req_o, 1'b0);
        check_bit("rst_iready", instr_ready_o, 1'b0);
        check_bit("rst_dready", data_ready_o, 1'b0);
        check("rst_irdata", instr_rdata_o, 32'h0);
        check("rst_drdata", data_rdata_o, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check_bit("rst_err", err_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Single fetch, memory answers two cycles after the request appears.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h100;
        settle(); check_bit("t1_idle", mem_req_o, 1'b0); advance();
        settle(); check("t1_addr", mem_addr_o, 32'h100); advance();
        settle(); advance();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        settle();
        check_bit("t1_ready", instr_ready_o, 1'b1);
        check("t1_rdata", instr_rdata_o, 32'h1234_5678);
        advance();
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        settle();
        check_bit("t1_back_idle", mem_req_o, 1'b0);
        check_bit("t1_one_pulse", instr_ready_o, 1'b0);
        check("t1_hold", instr_rdata_o, 32'h1234_5678);
        advance();

        // Simultaneous requests after reset: data first, instr back-to-back, next tie to data.
        do_reset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h200;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h300;
        settle(); advance();
        settle(); check("t2_data_first", mem_addr_o, 32'h300); advance();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hAAAA_0001;
        settle();
        check_bit("t2_dready", data_ready_o, 1'b1);
        check("t2_drdata", data_rdata_o, 32'hAAAA_0001);
        advance();
        data_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        settle();
        check_bit("t2_no_bubble", mem_req_o, 1'b1);
        check("t2_instr_addr", mem_addr_o, 32'h200);
        advance();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hBBBB_0002;
        settle();
        check_bit("t2_iready", instr_ready_o, 1'b1);
        check("t2_irdata", instr_rdata_o, 32'hBBBB_0002);
        check("t2_drdata_hold", data_rdata_o, 32'hAAAA_0001);
        advance();
        instr_addr_i = 32'h204;
        data_req_i   = 1'b1;
        data_addr_i  = 32'h304;
        mem_ready_i  = 1'b0;
        settle(); check_bit("t2_idle_gap", mem_req_o, 1'b0); advance();
        settle(); check("t2_tie_data", mem_addr_o, 32'h304); advance();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hCCCC_0003;
        settle(); check_bit("t2_dready2", data_ready_o, 1'b1); advance();
        data_req_i  = 1'b0;
        mem_rdata_i = 32'hDDDD_0004;
        settle();
        check("t2_instr_addr2", mem_addr_o, 32'h204);
        check("t2_irdata2", instr_rdata_o, 32'hDDDD_0004);
        advance();
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        settle(); advance();

        // Store holds write strobe, address and data for the whole BUSY phase.
        data_req_i   = 1'b1;
        data_write_i = 1'b1;
        data_addr_i  = 32'h2000;
        data_wdata_i = 32'hCAFE_F00D;
        settle(); advance();
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_ready_i = 1'b1;
            settle();
            check_bit("t3_write", mem_write_o, 1'b1);
            check("t3_addr", mem_addr_o, 32'h2000);
            check("t3_wdata", mem_wdata_o, 32'hCAFE_F00D);
            check_bit("t3_no_iready", instr_ready_o, 1'b0);
            advance();
        end
        data_req_i   = 1'b0;
        data_write_i = 1'b0;
        mem_ready_i  = 1'b0;
        settle(); check_bit("t3_write_idle", mem_write_o, 1'b0); advance();

        // Memory answers in exactly the cycle the watchdog would fire.
        do_reset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h44;
        settle(); advance();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = 32'h5555_AAAA;
            end
            settle();
            check_bit("t5_iready", instr_ready_o, k == TO);
            advance();
        end
        instr_req_i = 1'b0;
        mem_ready_i = 1'b0;
        settle();
        check_bit("t5_no_err", err_o, 1'b0);
        check("t5_rdata", instr_rdata_o, 32'h5555_AAAA);
        advance();

        // Fetch that never completes, then a second timeout that must not move err_addr.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h40;
        settle(); advance();
        for (int k = 1; k <= TO; k++) begin
            settle();
            check_bit("t4_iready", instr_ready_o, k == TO);
            if (k == TO) check("t4_err_rdata", instr_rdata_o, 32'hDEAD_BEEF);
            advance();
        end
        instr_req_i = 1'b0;
        settle();
        check_bit("t4_err", err_o, 1'b1);
        check("t4_err_addr", err_addr_o, 32'h40);
        check_bit("t4_req_drop", mem_req_o, 1'b0);
        advance();
        data_req_i  = 1'b1;
        data_addr_i = 32'h80;
        settle(); advance();
        for (int k = 1; k <= TO; k++) begin
            settle();
            check_bit("t4_dready", data_ready_o, k == TO);
            advance();
        end
        data_req_i = 1'b0;
        settle();
        check("t4_err_addr_kept", err_addr_o, 32'h40);
        check("t4_drdata", data_rdata_o, 32'hDEAD_BEEF);
        advance();

        // Reset in the middle of a data transaction aborts it without a completion pulse.
        data_req_i  = 1'b1;
        data_addr_i = 32'h600;
        settle(); advance();
        settle(); check_bit("t6_busy", mem_req_o, 1'b1); advance();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h6666_6666;
        #2;
        reset_i = 1'b1;
        #1;
        check_bit("t6_req_drop", mem_req_o, 1'b0);
        check_bit("t6_no_dready", data_ready_o, 1'b0);
        model_reset();
        clear_inputs();
        @(negedge clk_i);
        reset_i = 1'b0;
        settle();
        check_bit("t6_idle", mem_req_o, 1'b0);
        check_bit("t6_err_clear", err_o, 1'b0);
        advance();

        // Random traffic: requesters hold until their ready, memory answers with random latency.
        i_pend = 1'b0;
        d_pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!i_pend && $urandom_range(99) < 50) begin
                i_pend       = 1'b1;
                instr_addr_i = $urandom;
            end
            if (!d_pend && $urandom_range(99) < 50) begin
                d_pend       = 1'b1;
                data_write_i = 1'($urandom_range(1));
                data_addr_i  = $urandom;
                data_wdata_i = $urandom;
            end
            instr_req_i = i_pend;
            data_req_i  = d_pend;
            mem_ready_i = ($urandom_range(99) < 35);
            mem_rdata_i = $urandom;
            settle();
            advance();
            if (e_iready) i_pend = 1'b0;
            if (e_dready) d_pend = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
